// File: rtl/ap_ctrl_profiler.sv
// ap_ctrl_profiler: watches an ap_ctrl handshake and emits one record per
// transaction with its start/done timestamps, latency and start interval.
module ap_ctrl_profiler #(
    parameter int TS_W       = 32,
    parameter int PEND_DEPTH = 4,
    parameter int OUT_DEPTH  = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ap_start,
    input  logic            ap_ready,
    input  logic            ap_done,
    input  logic            ap_continue,
    input  logic            finish,
    output logic            rec_valid,
    input  logic            rec_ready,
    output logic [TS_W-1:0] rec_start_ts,
    output logic [TS_W-1:0] rec_done_ts,
    output logic [TS_W-1:0] rec_latency,
    output logic [TS_W-1:0] rec_interval,
    output logic [15:0]     drop_cnt,
    output logic [15:0]     orphan_cnt,
    output logic            pend_ovf,
    output logic            busy,
    output logic            sim_done
);

    localparam int PA = $clog2(PEND_DEPTH);
    localparam int OA = $clog2(OUT_DEPTH);
    localparam logic [PA:0] P_FULL = (PA+1)'(PEND_DEPTH);
    localparam logic [OA:0] O_FULL = (OA+1)'(OUT_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN,
        END
    } state_t;

    typedef struct packed {
        logic [TS_W-1:0] start_ts;
        logic [TS_W-1:0] done_ts;
        logic [TS_W-1:0] latency;
        logic [TS_W-1:0] interval;
    } rec_t;

    state_t          state;
    state_t          state_d;
    logic [TS_W-1:0] ts;
    logic            armed;

    logic [TS_W-1:0] pmem [PEND_DEPTH];
    logic [PA-1:0]   p_rd;
    logic [PA-1:0]   p_wr;
    logic [PA:0]     p_cnt;

    rec_t            omem [OUT_DEPTH];
    logic [OA-1:0]   o_rd;
    logic [OA-1:0]   o_wr;
    logic [OA:0]     o_cnt;

    logic [TS_W-1:0] prev_s;
    logic            have_prev;

    logic            take_start;
    logic            start_ev;
    logic            done_ev;
    logic            p_empty;
    logic            p_full;
    logic            p_pop;
    logic            p_push;
    logic            bypass;
    logic            orphan;
    logic            ovf;
    logic            mk_rec;
    logic [TS_W-1:0] s_val;
    rec_t            rec_new;
    rec_t            head;
    logic            o_pop;
    logic            o_full;
    logic            o_push;
    logic            drop;

    always_comb begin
        take_start = (state == IDLE) || (state == ACTIVE);
        start_ev   = take_start && ap_start && armed;
        done_ev    = (state != END) && ap_done && ap_continue;
        p_empty    = (p_cnt == '0);
        p_full     = (p_cnt == P_FULL);
        // a done with nothing queued can still pair with this cycle's start
        p_pop      = done_ev && !p_empty;
        bypass     = done_ev && p_empty && start_ev;
        orphan     = done_ev && p_empty && !start_ev;
        p_push     = start_ev && !bypass && (!p_full || p_pop);
        ovf        = start_ev && !bypass && p_full && !p_pop;
        mk_rec     = p_pop || bypass;
        s_val      = p_pop ? pmem[p_rd] : ts;
        rec_new.start_ts = s_val;
        rec_new.done_ts  = ts;
        rec_new.latency  = ts - s_val;
        rec_new.interval = have_prev ? s_val - prev_s : '0;
        o_full     = (o_cnt == O_FULL);
        o_pop      = rec_valid && rec_ready;
        o_push     = mk_rec && (!o_full || o_pop);
        drop       = mk_rec && o_full && !o_pop;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (finish)        state_d = DRAIN;
                else if (start_ev) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (finish) state_d = DRAIN;
            end
            DRAIN: begin
                if (p_empty && o_cnt == '0) state_d = END;
            end
            END: state_d = END;
        endcase
    end

    always_ff @(posedge clock) begin
        if (p_push) pmem[p_wr] <= ts;
        if (o_push) omem[o_wr] <= rec_new;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ts        <= '0;
            armed     <= 1'b1;
            p_rd      <= '0;
            p_wr      <= '0;
            p_cnt     <= '0;
            o_rd      <= '0;
            o_wr      <= '0;
            o_cnt     <= '0;
            prev_s    <= '0;
            have_prev <= 1'b0;
            drop_cnt  <= '0;
            orphan_cnt <= '0;
            pend_ovf  <= 1'b0;
        end else begin
            state <= state_d;
            ts    <= ts + TS_W'(1);
            if (take_start) begin
                if (ap_ready)      armed <= 1'b1;
                else if (start_ev) armed <= 1'b0;
            end
            if (p_push) p_wr <= p_wr + PA'(1);
            if (p_pop)  p_rd <= p_rd + PA'(1);
            case ({p_push, p_pop})
                2'b10:   p_cnt <= p_cnt + (PA+1)'(1);
                2'b01:   p_cnt <= p_cnt - (PA+1)'(1);
                default: ;
            endcase
            if (o_push) o_wr <= o_wr + OA'(1);
            if (o_pop)  o_rd <= o_rd + OA'(1);
            case ({o_push, o_pop})
                2'b10:   o_cnt <= o_cnt + (OA+1)'(1);
                2'b01:   o_cnt <= o_cnt - (OA+1)'(1);
                default: ;
            endcase
            // interval chain follows built records, dropped or not
            if (mk_rec) begin
                prev_s    <= s_val;
                have_prev <= 1'b1;
            end
            if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            if (orphan && orphan_cnt != 16'hFFFF)
                orphan_cnt <= orphan_cnt + 16'd1;
            if (ovf) pend_ovf <= 1'b1;
        end
    end

    assign head         = omem[o_rd];
    assign rec_valid    = (o_cnt != '0);
    assign rec_start_ts = rec_valid ? head.start_ts : '0;
    assign rec_done_ts  = rec_valid ? head.done_ts  : '0;
    assign rec_latency  = rec_valid ? head.latency  : '0;
    assign rec_interval = rec_valid ? head.interval : '0;
    assign busy         = !p_empty;
    assign sim_done     = (state == END);

endmodule

// File: tb/tb_ap_ctrl_profiler.sv
// tb_ap_ctrl_profiler: directed scenarios plus a randomized run against a
// queue-based transaction model of the profiler.
module tb_ap_ctrl_profiler;

    localparam int PEND = 4;
    localparam int OUTD = 8;

    typedef struct packed {
        logic [31:0] s;
        logic [31:0] d;
        logic [31:0] l;
        logic [31:0] i;
    } trec_t;

    logic        clock;
    logic        reset;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_done;
    logic        ap_continue;
    logic        finish;
    logic        rec_valid;
    logic        rec_ready;
    logic [31:0] rec_start_ts;
    logic [31:0] rec_done_ts;
    logic [31:0] rec_latency;
    logic [31:0] rec_interval;
    logic [15:0] drop_cnt;
    logic [15:0] orphan_cnt;
    logic        pend_ovf;
    logic        busy;
    logic        sim_done;

    int checks = 0;
    int passed = 0;
    int tcur = 0;

    logic [31:0] pq[$];
    trec_t       oq[$];
    logic [31:0] m_ts;
    logic        m_armed;
    int          m_state;
    logic [31:0] m_prev;
    logic        m_have;
    logic [15:0] m_drop;
    logic [15:0] m_orphan;
    logic        m_ovf;

    ap_ctrl_profiler #(
        .TS_W(32),
        .PEND_DEPTH(PEND),
        .OUT_DEPTH(OUTD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ap_start(ap_start),
        .ap_ready(ap_ready),
        .ap_done(ap_done),
        .ap_continue(ap_continue),
        .finish(finish),
        .rec_valid(rec_valid),
        .rec_ready(rec_ready),
        .rec_start_ts(rec_start_ts),
        .rec_done_ts(rec_done_ts),
        .rec_latency(rec_latency),
        .rec_interval(rec_interval),
        .drop_cnt(drop_cnt),
        .orphan_cnt(orphan_cnt),
        .pend_ovf(pend_ovf),
        .busy(busy),
        .sim_done(sim_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [128:0] got_rec();
        return {rec_valid, rec_start_ts, rec_done_ts,
                rec_latency, rec_interval};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        tcur++;
    endtask

    task automatic run_to(input int n);
        while (tcur < n) tick();
    endtask

    task automatic clr();
        ap_start = 0;
        ap_ready = 0;
        ap_done = 0;
        ap_continue = 0;
        finish = 0;
    endtask

    task automatic model_reset();
        pq.delete();
        oq.delete();
        m_ts = 0;
        m_armed = 1;
        m_state = 0;
        m_prev = 0;
        m_have = 0;
        m_drop = 0;
        m_orphan = 0;
        m_ovf = 0;
    endtask

    task automatic apply_reset();
        reset = 1;
        clr();
        tick();
        tick();
        reset = 0;
        tcur = 0;
        model_reset();
    endtask

    // state: 0 idle, 1 active, 2 drain, 3 end
    task automatic model_step();
        bit acc, st, dn, used, mk, drain_ok;
        logic [31:0] s;
        trec_t r;
        drain_ok = (pq.size() == 0) && (oq.size() == 0);
        acc = (m_state == 0) || (m_state == 1);
        st = acc && ap_start && m_armed;
        dn = (m_state != 3) && ap_done && ap_continue;
        used = 0;
        mk = 0;
        s = 0;
        if (dn) begin
            if (pq.size() != 0) begin
                s = pq.pop_front();
                mk = 1;
            end else if (st) begin
                s = m_ts;
                mk = 1;
                used = 1;
            end else if (m_orphan != 16'hFFFF) begin
                m_orphan++;
            end
        end
        if (st && !used) begin
            if (pq.size() < PEND) pq.push_back(m_ts);
            else m_ovf = 1;
        end
        if (oq.size() != 0 && rec_ready) oq.delete(0);
        if (mk) begin
            r.s = s;
            r.d = m_ts;
            r.l = m_ts - s;
            r.i = m_have ? s - m_prev : 32'd0;
            m_prev = s;
            m_have = 1;
            if (oq.size() < OUTD) oq.push_back(r);
            else if (m_drop != 16'hFFFF) m_drop++;
        end
        if (acc) begin
            if (ap_ready) m_armed = 1;
            else if (st) m_armed = 0;
        end
        case (m_state)
            0: if (finish) m_state = 2; else if (st) m_state = 1;
            1: if (finish) m_state = 2;
            2: if (drain_ok) m_state = 3;
            default: ;
        endcase
        m_ts++;
    endtask

    task automatic test_reset();
        reset = 1;
        clr();
        rec_ready = 0;
        #1;
        checks++;
        if ({got_rec(), drop_cnt, orphan_cnt, pend_ovf, busy, sim_done} !== '0)
            $display("FAIL reset_outputs: got %h %0d %0d %b%b%b want all zero",
                     got_rec(), drop_cnt, orphan_cnt, pend_ovf, busy, sim_done);
        else passed++;
    endtask

    task automatic test_single();
        apply_reset();
        rec_ready = 1;
        run_to(10);
        ap_start = 1;
        ap_ready = 1;
        tick();
        clr();
        run_to(15);
        checks++;
        if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy);
        else passed++;
        run_to(25);
        checks++;
        if (rec_valid !== 1'b0)
            $display("FAIL single_early: got %b want 0", rec_valid);
        else passed++;
        ap_done = 1;
        ap_continue = 1;
        tick();
        clr();
        checks++;
        if (got_rec() !== {1'b1, 32'd10, 32'd25, 32'd15, 32'd0})
            $display("FAIL single_rec: got %h want 1/10/25/15/0", got_rec());
        else passed++;
        tick();
        checks++;
        if ({rec_valid, busy} !== 2'b00)
            $display("FAIL single_after: got %b%b want 00", rec_valid, busy);
        else passed++;
    endtask

    task automatic test_pipelined();
        logic [128:0] want;
        apply_reset();
        rec_ready = 1;
        for (int i = 0; i < 3; i++) begin
            run_to(5 + 3 * i);
            ap_start = 1;
            ap_ready = 1;
            tick();
            clr();
        end
        for (int i = 0; i < 3; i++) begin
            run_to(20 + 3 * i);
            ap_done = 1;
            ap_continue = 1;
            tick();
            clr();
            want = {1'b1, 32'(5 + 3 * i), 32'(20 + 3 * i), 32'd15,
                    (i == 0) ? 32'd0 : 32'd3};
            checks++;
            if (got_rec() !== want)
                $display("FAIL pipe_rec%0d: got %h want %h", i, got_rec(), want);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [128:0] want;
        apply_reset();
        rec_ready = 0;
        for (int i = 0; i < 10; i++) begin
            run_to(10 + 3 * i);
            ap_start = 1;
            ap_ready = 1;
            tick();
            clr();
            run_to(12 + 3 * i);
            ap_done = 1;
            ap_continue = 1;
            tick();
            clr();
        end
        checks++;
        if ({rec_valid, drop_cnt} !== {1'b1, 16'd2})
            $display("FAIL bp_drop: got v=%b drop=%0d want v=1 drop=2",
                     rec_valid, drop_cnt);
        else passed++;
        rec_ready = 1;
        for (int i = 0; i < 8; i++) begin
            want = {1'b1, 32'(10 + 3 * i), 32'(12 + 3 * i), 32'd2,
                    (i == 0) ? 32'd0 : 32'd3};
            checks++;
            if (got_rec() !== want)
                $display("FAIL bp_rec%0d: got %h want %h", i, got_rec(), want);
            else passed++;
            tick();
        end
        checks++;
        if (rec_valid !== 1'b0)
            $display("FAIL bp_empty: got %b want 0", rec_valid);
        else passed++;
    endtask

    task automatic test_same_cycle();
        apply_reset();
        rec_ready = 0;
        run_to(40);
        ap_start = 1;
        ap_ready = 1;
        ap_done = 1;
        ap_continue = 1;
        tick();
        clr();
        checks++;
        if ({got_rec(), busy} !== {1'b1, 32'd40, 32'd40, 32'd0, 32'd0, 1'b0})
            $display("FAIL same_rec: got %h busy=%b want 1/40/40/0/0 busy=0",
                     got_rec(), busy);
        else passed++;
        run_to(50);
        ap_done = 1;
        ap_continue = 1;
        tick();
        clr();
        checks++;
        if ({orphan_cnt, drop_cnt, pend_ovf} !== {16'd1, 16'd0, 1'b0})
            $display("FAIL orphan: got orphan=%0d drop=%0d ovf=%b want 1 0 0",
                     orphan_cnt, drop_cnt, pend_ovf);
        else passed++;
    endtask

    task automatic test_overflow();
        logic [128:0] want;
        apply_reset();
        rec_ready = 0;
        run_to(2);
        ap_start = 1;
        ap_ready = 1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                checks++;
                if (pend_ovf !== 1'b0)
                    $display("FAIL ovf_early: got %b want 0", pend_ovf);
                else passed++;
            end
            tick();
        end
        clr();
        checks++;
        if ({pend_ovf, busy} !== 2'b11)
            $display("FAIL ovf_set: got ovf=%b busy=%b want 11", pend_ovf, busy);
        else passed++;
        run_to(10);
        ap_done = 1;
        ap_continue = 1;
        repeat (4) tick();
        clr();
        checks++;
        if ({pend_ovf, busy} !== 2'b10)
            $display("FAIL ovf_sticky: got ovf=%b busy=%b want 10", pend_ovf, busy);
        else passed++;
        rec_ready = 1;
        for (int k = 0; k < 4; k++) begin
            want = {1'b1, 32'(2 + k), 32'(10 + k), 32'd8,
                    (k == 0) ? 32'd0 : 32'd1};
            checks++;
            if (got_rec() !== want)
                $display("FAIL ovf_rec%0d: got %h want %h", k, got_rec(), want);
            else passed++;
            tick();
        end
        checks++;
        if ({rec_valid, orphan_cnt, drop_cnt} !== '0)
            $display("FAIL ovf_end: got v=%b orphan=%0d drop=%0d want 0",
                     rec_valid, orphan_cnt, drop_cnt);
        else passed++;
    endtask

    task automatic test_idle_finish();
        apply_reset();
        run_to(3);
        finish = 1;
        tick();
        finish = 0;
        checks++;
        if (sim_done !== 1'b0)
            $display("FAIL idle_fin_drain: got %b want 0", sim_done);
        else passed++;
        tick();
        checks++;
        if (sim_done !== 1'b1)
            $display("FAIL idle_fin_end: got %b want 1", sim_done);
        else passed++;
    endtask

    task automatic test_drain();
        int w;
        apply_reset();
        rec_ready = 0;
        run_to(2);
        ap_start = 1;
        ap_ready = 1;
        repeat (2) tick();
        clr();
        run_to(5);
        finish = 1;
        tick();
        finish = 0;
        ap_start = 1;
        ap_ready = 1;
        repeat (2) tick();
        clr();
        checks++;
        if ({busy, sim_done} !== 2'b10)
            $display("FAIL drain_hold: got busy=%b done=%b want 10", busy, sim_done);
        else passed++;
        run_to(10);
        ap_done = 1;
        ap_continue = 1;
        repeat (2) tick();
        clr();
        checks++;
        if ({busy, rec_valid, sim_done} !== 3'b010)
            $display("FAIL drain_ignored: got busy=%b v=%b done=%b want 010",
                     busy, rec_valid, sim_done);
        else passed++;
        rec_ready = 1;
        checks++;
        if (got_rec() !== {1'b1, 32'd2, 32'd10, 32'd8, 32'd0})
            $display("FAIL drain_rec0: got %h want 1/2/10/8/0", got_rec());
        else passed++;
        tick();
        checks++;
        if (got_rec() !== {1'b1, 32'd3, 32'd11, 32'd8, 32'd1})
            $display("FAIL drain_rec1: got %h want 1/3/11/8/1", got_rec());
        else passed++;
        tick();
        w = 0;
        while (!sim_done && w < 4) begin
            tick();
            w++;
        end
        checks++;
        if (sim_done !== 1'b1)
            $display("FAIL drain_end: got %b want 1 within 4 cycles", sim_done);
        else passed++;
        ap_start = 1;
        ap_ready = 1;
        ap_done = 1;
        ap_continue = 1;
        repeat (3) tick();
        clr();
        checks++;
        if ({sim_done, rec_valid, busy, orphan_cnt} !== {3'b100, 16'd0})
            $display("FAIL end_absorb: got done=%b v=%b busy=%b orphan=%0d want 1 0 0 0",
                     sim_done, rec_valid, busy, orphan_cnt);
        else passed++;
    endtask

    task automatic test_reset_in_drain();
        apply_reset();
        rec_ready = 0;
        run_to(2);
        ap_start = 1;
        ap_ready = 1;
        tick();
        finish = 1;
        tick();
        clr();
        ap_done = 1;
        ap_continue = 1;
        tick();
        clr();
        checks++;
        if ({rec_valid, busy, sim_done} !== 3'b110)
            $display("FAIL pre_reset: got v=%b busy=%b done=%b want 110",
                     rec_valid, busy, sim_done);
        else passed++;
        #2;
        reset = 1;
        #1;
        checks++;
        if ({got_rec(), drop_cnt, orphan_cnt, pend_ovf, busy, sim_done} !== '0)
            $display("FAIL async_reset: got %h %0d %0d %b%b%b want all zero",
                     got_rec(), drop_cnt, orphan_cnt, pend_ovf, busy, sim_done);
        else passed++;
        @(posedge clock);
        #1;
        reset = 0;
        tcur = 0;
        run_to(3);
        ap_done = 1;
        ap_continue = 1;
        tick();
        clr();
        checks++;
        if ({orphan_cnt, rec_valid, busy} !== {16'd1, 2'b00})
            $display("FAIL post_reset_orphan: got orphan=%0d v=%b busy=%b want 1 0 0",
                     orphan_cnt, rec_valid, busy);
        else passed++;
    endtask

    task automatic test_random();
        trec_t er;
        logic  ev;
        apply_reset();
        for (int n = 0; n < 4000; n++) begin
            ev = (oq.size() != 0);
            er = ev ? oq[0] : '0;
            checks++;
            if (got_rec() !== {ev, er.s, er.d, er.l, er.i})
                $display("FAIL rand_rec n=%0d: got %h want %h",
                         n, got_rec(), {ev, er.s, er.d, er.l, er.i});
            else passed++;
            checks++;
            if ({busy, pend_ovf, drop_cnt, orphan_cnt, sim_done} !==
                {(pq.size() != 0), m_ovf, m_drop, m_orphan, (m_state == 3)})
                $display("FAIL rand_stat n=%0d: got b=%b o=%b d=%0d r=%0d s=%b want b=%b o=%b d=%0d r=%0d s=%b",
                         n, busy, pend_ovf, drop_cnt, orphan_cnt, sim_done,
                         (pq.size() != 0), m_ovf, m_drop, m_orphan,
                         (m_state == 3));
            else passed++;
            if (n == 2000) begin
                apply_reset();
                continue;
            end
            ap_start    = ($urandom_range(99) < 40);
            ap_ready    = ($urandom_range(99) < 50);
            ap_done     = ($urandom_range(99) < 30);
            ap_continue = ($urandom_range(99) < 80);
            rec_ready   = ($urandom_range(99) < 60);
            finish      = (n == 3600);
            model_step();
            tick();
        end
        clr();
    endtask

    initial begin
        test_reset();
        test_single();
        test_pipelined();
        test_back_to_back();
        test_same_cycle();
        test_overflow();
        test_idle_finish();
        test_drain();
        test_reset_in_drain();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
